// File: rtl/d_ff_response_checker_if.sv
// d_ff_response_checker_if: bundles the flip-flop stimulus/response signals and the checker's results
interface d_ff_response_checker_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             d;
    logic             q;
    logic             qn;
    logic             exp_q;
    logic             mismatch;
    logic             comp_err;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] checked_cnt;
    logic             fail;
    logic [1:0]       state;

    modport master (
        output en, d, q, qn,
        input  exp_q, mismatch, comp_err, err_cnt, checked_cnt, fail, state
    );

    modport slave (
        input  en, d, q, qn,
        output exp_q, mismatch, comp_err, err_cnt, checked_cnt, fail, state
    );
endinterface

// File: rtl/d_ff_response_checker.sv
// d_ff_response_checker: compares a DUT flip-flop's Q/Qn against a one-cycle reference model
module d_ff_response_checker #(
    parameter int CNT_W        = 8,
    parameter int WARMUP       = 2,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    d_ff_response_checker_if.slave  bus
);
    // Warm-up counter only needs to hold WARMUP-1; keep at least one bit so WARMUP=0/1 still elaborate.
    localparam int            WW     = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [WW-1:0] W_LOAD = WW'((WARMUP > 0) ? WARMUP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WARM  = 2'b01,
        S_CHECK = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    state_t           r_state, w_next;
    logic [WW-1:0]    r_wcnt, w_wcnt;
    logic [CNT_W-1:0] r_err, w_err;
    logic [CNT_W-1:0] r_chk, w_chk;
    logic             r_exp, r_mis, r_comp, r_fail;
    logic             w_mis, w_comp, w_fail;
    logic             w_em, w_ec;

    // Errors are judged against the model value captured on the previous edge.
    assign w_em = bus.q != r_exp;
    assign w_ec = bus.q == bus.qn;

    // Next state, warm-up count, compare pulses and result counters.
    always_comb begin
        w_next = r_state;
        w_wcnt = r_wcnt;
        w_err  = r_err;
        w_chk  = r_chk;
        w_fail = r_fail;
        w_mis  = 1'b0;
        w_comp = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.en) begin
                    w_err  = '0;
                    w_chk  = '0;
                    w_fail = 1'b0;
                    w_wcnt = W_LOAD;
                    w_next = (WARMUP > 0) ? S_WARM : S_CHECK;
                end
            end
            S_WARM: begin
                w_wcnt = r_wcnt - 1'b1;
                w_next = !bus.en ? S_IDLE : ((r_wcnt == '0) ? S_CHECK : S_WARM);
            end
            S_CHECK: begin
                if (!bus.en) begin
                    w_next = S_IDLE;
                end else begin
                    w_mis  = w_em;
                    w_comp = w_ec;
                    w_chk  = (&r_chk) ? r_chk : r_chk + 1'b1;
                    if (w_em || w_ec) begin
                        w_err  = (&r_err) ? r_err : r_err + 1'b1;
                        w_fail = 1'b1;
                        if (STOP_ON_FAIL) w_next = S_HALT;
                    end
                end
            end
            default: begin
                if (!bus.en) w_next = S_IDLE;
            end
        endcase
    end

    // State, model and result registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
            r_err   <= '0;
            r_chk   <= '0;
            r_exp   <= 1'b0;
            r_mis   <= 1'b0;
            r_comp  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wcnt  <= w_wcnt;
            r_err   <= w_err;
            r_chk   <= w_chk;
            r_exp   <= bus.d;
            r_mis   <= w_mis;
            r_comp  <= w_comp;
            r_fail  <= w_fail;
        end
    end

    assign bus.exp_q       = r_exp;
    assign bus.mismatch    = r_mis;
    assign bus.comp_err    = r_comp;
    assign bus.err_cnt     = r_err;
    assign bus.checked_cnt = r_chk;
    assign bus.fail        = r_fail;
    assign bus.state       = r_state;
endmodule
